// File: rtl/spi_slave_word_rx_if.sv
// Serial link and word-side signals of the SPI word receiver.
// The slave modport is the receiver's view; the master modport is the driver's view.
interface spi_slave_word_rx_if;
  logic        i_SPI_Clk;
  logic        i_SPI_MOSI;
  logic        o_SPI_MISO;
  logic [15:0] i_TX_Word;
  logic [15:0] o_RX_Word;
  logic        o_RX_DV;
  logic        o_Busy;
  logic        o_Frame_Err;

  modport slave (
    input  i_SPI_Clk, i_SPI_MOSI, i_TX_Word,
    output o_SPI_MISO, o_RX_Word, o_RX_DV, o_Busy, o_Frame_Err
  );

  modport master (
    output i_SPI_Clk, i_SPI_MOSI, i_TX_Word,
    input  o_SPI_MISO, o_RX_Word, o_RX_DV, o_Busy, o_Frame_Err
  );
endinterface

// File: rtl/spi_slave_word_rx.sv
// SPI mode-0 slave for 16-bit words sent as two MSB-first bytes, low byte first.
// SCK/MOSI are oversampled in the i_Clk domain; framing is by bit count with an idle-timeout abort.
module spi_slave_word_rx #(
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  spi_slave_word_rx_if.slave   bus
);

  localparam int unsigned TO_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_LOW  = 2'd1,
    RX_HIGH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [7:0]             rx_lo_q, rx_lo_d;
  logic [6:0]             rx_hi_q, rx_hi_d;
  logic [14:0]            tx_q, tx_d;
  logic                   miso_q, miso_d;
  logic [15:0]            rx_word_q, rx_word_d;
  logic                   rx_dv_q, rx_dv_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  logic sck_s, mosi_s, sck_rise, sck_fall;

  // Equal-depth synchronizers keep MOSI aligned with the SCK edge that samples it
  assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.i_SPI_Clk};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sck_prev_d  = sck_s;
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      rx_lo_q     <= '0;
      rx_hi_q     <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      rx_word_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rx_lo_q     <= rx_lo_d;
      rx_hi_q     <= rx_hi_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      rx_word_q   <= rx_word_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
    end
  end

  // tx_q holds the response bits still to go out, low byte first, after the one already on MISO
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    rx_lo_d     = rx_lo_q;
    rx_hi_d     = rx_hi_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    rx_word_d   = rx_word_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d      = {bus.i_TX_Word[6:0], bus.i_TX_Word[15:8]};
        miso_d    = bus.i_TX_Word[7];
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        if (sck_rise) begin
          rx_lo_d   = {7'b0, mosi_s};
          bit_cnt_d = CNT_W'(1);
          state_d   = RX_LOW;
        end
      end

      RX_LOW, RX_HIGH: begin
        if (sck_rise) begin
          to_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (state_q == RX_LOW) begin
            rx_lo_d = {rx_lo_q[6:0], mosi_s};
          end else begin
            rx_hi_d = {rx_hi_q[5:0], mosi_s};
          end
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            if (state_q == RX_LOW) begin
              state_d = RX_HIGH;
            end else begin
              state_d   = IDLE;
              rx_word_d = {rx_hi_q, mosi_s, rx_lo_q};
              rx_dv_d   = 1'b1;
            end
          end
        end else if (sck_fall) begin
          to_cnt_d = '0;
          miso_d   = tx_q[14];
          tx_d     = {tx_q[13:0], 1'b0};
        end else if (to_cnt_q == TO_W'(IDLE_TIMEOUT - 1)) begin
          // A rise in this same cycle takes the branch above, so the abort only fires on a true stall
          state_d     = IDLE;
          to_cnt_d    = '0;
          bit_cnt_d   = '0;
          frame_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.o_SPI_MISO  = miso_q;
  assign bus.o_RX_Word   = rx_word_q;
  assign bus.o_RX_DV     = rx_dv_q;
  assign bus.o_Busy      = busy_q;
  assign bus.o_Frame_Err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_word_rx.sv
// Bench for spi_slave_word_rx: a mode-0 master model drives frames; a negedge monitor
// scores received words against a queue of sent words and drains queued point checks.
module tb_spi_slave_word_rx;

  localparam int unsigned TO   = 64;
  localparam int unsigned SS   = 2;
  localparam int          HMIN = SS + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_word_rx_if bus();

  spi_slave_word_rx #(.IDLE_TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned fall_cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          err_cnt = 0;
  int          half;
  logic [15:0] last_word;
  logic [15:0] exp_rx_q[$];
  chk_t        chk_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scores every data-valid and frame-error pulse plus any queued point checks
  always @(negedge clk) begin
    logic [15:0] e;
    chk_t        c;
    if (!rst) begin
      if (bus.o_RX_DV) begin
        checks++;
        if (exp_rx_q.size() == 0) begin
          failures++;
          $display("FAIL rx_dv_unexpected act=%h req=no_pulse", bus.o_RX_Word);
        end else begin
          e = exp_rx_q.pop_front();
          if (bus.o_RX_Word !== e) begin
            failures++;
            $display("FAIL rx_word act=%h req=%h", bus.o_RX_Word, e);
          end
        end
        checks++;
        if (cyc - rise_cyc != SS + 1) begin
          failures++;
          $display("FAIL rx_dv_latency act=%0d req=%0d", cyc - rise_cyc, SS + 1);
        end
      end
      if (bus.o_Frame_Err) begin
        err_cnt++;
        checks++;
        if (cyc - fall_cyc != SS + TO + 1) begin
          failures++;
          $display("FAIL frame_err_latency act=%0d req=%0d", cyc - fall_cyc, SS + TO + 1);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        failures++;
        $display("FAIL %s act=%h req=%h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic push_chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mode-0 master: MOSI set while SCK low, MISO sampled at the rising edge.
  // Bit order on the wire: w[7:0] MSB-first, then w[15:8] MSB-first.
  task automatic xfer(input logic [15:0] w, input int nbits, input int pause_after,
                      input int pause_len, input int chg_at, input logic [15:0] chg_val,
                      output logic [15:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = (i < 8) ? (7 - i) : (15 - (i - 8));
      if (i == chg_at) bus.i_TX_Word = chg_val;
      bus.i_SPI_MOSI = w[b];
      wait_cycles(half);
      got[b] = bus.o_SPI_MISO;
      bus.i_SPI_Clk = 1'b1;
      rise_cyc = cyc;
      if (i == 4) push_chk("busy_mid_frame", 32'(bus.o_Busy), 32'd1);
      wait_cycles(half);
      bus.i_SPI_Clk = 1'b0;
      fall_cyc = cyc;
      if (i == pause_after) wait_cycles(pause_len);
    end
  endtask

  // Full frame: the slave must report w, and the master must receive the word held at frame start
  task automatic frame(input logic [15:0] w, input int chg_at, input logic [15:0] chg_val,
                       input int pause_after, input int pause_len);
    logic [15:0] got;
    logic [15:0] tx0;
    tx0 = bus.i_TX_Word;
    exp_rx_q.push_back(w);
    last_word = w;
    xfer(w, 16, pause_after, pause_len, chg_at, chg_val, got);
    push_chk("miso_word", 32'(got), 32'(tx0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dummy;
    logic [15:0] w;
    rst = 1'b1;
    bus.i_SPI_Clk  = 1'b0;
    bus.i_SPI_MOSI = 1'b0;
    bus.i_TX_Word  = 16'h0000;
    half = 6;
    last_word = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(2);
    push_chk("reset_rx_word", 32'(bus.o_RX_Word), 32'h0);
    push_chk("reset_rx_dv", 32'(bus.o_RX_DV), 32'h0);
    push_chk("reset_busy", 32'(bus.o_Busy), 32'h0);
    push_chk("reset_frame_err", 32'(bus.o_Frame_Err), 32'h0);

    // Basic frame
    bus.i_TX_Word = 16'h1234;
    wait_cycles(3);
    frame(16'hA53C, -1, 16'h0, -1, 0);
    wait_cycles(4);
    push_chk("busy_after_frame", 32'(bus.o_Busy), 32'h0);

    // Back-to-back frames with no extra gap
    frame(16'h0001, -1, 16'h0, -1, 0);
    frame(16'hFFFF, -1, 16'h0, -1, 0);
    wait_cycles(4);

    // Stalled partial frame aborts via timeout
    xfer(16'h5A5A, 5, -1, 0, -1, 16'h0, dummy);
    wait_cycles(TO + 10);
    push_chk("timeout_err_count", 32'(err_cnt), 32'd1);
    push_chk("timeout_rx_word_kept", 32'(bus.o_RX_Word), 32'(last_word));
    push_chk("timeout_busy", 32'(bus.o_Busy), 32'h0);
    frame(16'hBEEF, -1, 16'h0, -1, 0);
    wait_cycles(4);

    // Reset after the first byte discards the partial frame
    xfer(16'hC3C3, 8, -1, 0, -1, 16'h0, dummy);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    push_chk("midrst_rx_word", 32'(bus.o_RX_Word), 32'h0);
    push_chk("midrst_rx_dv", 32'(bus.o_RX_DV), 32'h0);
    push_chk("midrst_busy", 32'(bus.o_Busy), 32'h0);
    push_chk("midrst_frame_err", 32'(bus.o_Frame_Err), 32'h0);
    push_chk("midrst_miso", 32'(bus.o_SPI_MISO), 32'h0);
    last_word = 16'h0000;
    wait_cycles(3);
    frame(16'h5AA5, -1, 16'h0, -1, 0);
    wait_cycles(4);

    // Response word change mid-frame is ignored until the next frame
    bus.i_TX_Word = 16'h1234;
    wait_cycles(3);
    frame(16'h6789, 3, 16'hFFFF, -1, 0);
    wait_cycles(4);
    frame(16'h0F0F, -1, 16'h0, -1, 0);
    wait_cycles(4);

    // A long stall just short of the timeout keeps the frame alive
    frame(16'h3C96, -1, 16'h0, 10, TO - 8);
    wait_cycles(4);

    // Randomized frames at the minimum SCK half-period
    half = HMIN;
    for (int n = 0; n < 200; n++) begin
      bus.i_TX_Word = 16'($urandom);
      wait_cycles(int'($urandom_range(0, 3)));
      w = 16'($urandom);
      frame(w, -1, 16'h0, -1, 0);
    end

    wait_cycles(10);
    push_chk("final_err_count", 32'(err_cnt), 32'd1);
    push_chk("final_rx_pending", 32'(exp_rx_q.size()), 32'd0);
    push_chk("final_rx_word", 32'(bus.o_RX_Word), 32'(last_word));
    wait_cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_word_rx.md
Name: spi_slave_word_rx

Overview:
- SPI mode-0 slave; the far end of the team's 16-bit-word SPI master link.
- The master sends each word as two MSB-first bytes: the low (address) byte first, then the high (data) byte.
- This block oversamples SCK/MOSI in the i_Clk domain, reassembles the 16-bit word, pulses a data-valid, and shifts a 16-bit response word back on MISO.
- No chip select exists on the link: framing is by bit count, with an idle-timeout resync.

Parameters:
- IDLE_TIMEOUT, 64: i_Clk cycles without a synchronized SCK edge while mid-frame before the frame is aborted.
- SYNC_STAGES, 2: synchronizer flops on i_SPI_Clk and i_SPI_MOSI; range 2..3.

Ports:
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_SPI_Clk  in  1  SCK from master; asynchronous to i_Clk.
- i_SPI_MOSI  in  1  serial data from master.
- o_SPI_MISO  out  1  serial response to master.
- i_TX_Word  in  16  response word; sampled at frame start.
- o_RX_Word  out  16  received word, {second byte, first byte}.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Word valid in that cycle and held after.
- o_Busy  out  1  high while a frame is in progress (state RX_LOW or RX_HIGH).
- o_Frame_Err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (synchronous, i_Rst=1 at a clock edge):
  - State = IDLE; bit counter = 0; timeout counter = 0.
  - o_RX_Word=0, o_RX_DV=0, o_Frame_Err=0, o_Busy=0, o_SPI_MISO=0.
  - Synchronizer flops cleared to 0.
  - Reset mid-frame discards partial data and emits no pulse.
- Synchronization and edge detection:
  - SCK and MOSI pass through equal SYNC_STAGES pipelines.
  - Rise = sync SCK 0->1; fall = sync SCK 1->0, each detected in one i_Clk cycle.
  - MOSI is sampled from the synchronized MOSI in the rise cycle.
- Timing requirement: SCK high and low times are each >= SYNC_STAGES+2 i_Clk cycles, so MISO updates before the master's next rising edge. The team's master at CLKS_PER_HALF_BIT=2 therefore needs the slave i_Clk >= 2x the master clock.
- IDLE state:
  - Each cycle, load tx shift reg <= i_TX_Word and drive o_SPI_MISO = i_TX_Word[7] (low byte MSB is first out).
  - The first rise moves the block to RX_LOW and samples bit 7 of byte 0.
- RX_LOW:
  - Each rise: rx_lo <= {rx_lo[6:0], MOSI}, counter +1.
  - Each fall: shift the next tx bit onto MISO, order [7:0] MSB-first.
  - After the 8th rise: counter=0, go to RX_HIGH.
  - On the fall that follows, MISO = tx[15].
- RX_HIGH:
  - Same shifting into rx_hi; MISO walks tx[15:8].
  - On the 8th rise: the next cycle has o_RX_Word = {rx_hi_final, rx_lo} and o_RX_DV=1 for exactly one cycle. Latency is 1 cycle after the rise-detect cycle.
  - Then go to IDLE.
- Timeout:
  - Counter clears on any rise or fall; increments otherwise while in RX_LOW/RX_HIGH.
  - On reaching IDLE_TIMEOUT: pulse o_Frame_Err, go to IDLE, clear counters, keep o_RX_Word unchanged, no o_RX_DV.
  - The timeout is not checked in IDLE.
- Simultaneous events: a rise in the same cycle the timeout hits is treated as a rise; the timeout loses.
- Response word: i_TX_Word changes mid-frame are ignored.
- Idle-level MISO: after a frame, the IDLE reload presents the new i_TX_Word[7] immediately.

Test Plan:
- Reset, then master sends word 16'hA53C (bytes 3C then A5) with i_TX_Word=16'h1234 -> one o_RX_DV pulse, o_RX_Word=16'hA53C; master receives bytes 34 then 12; o_Busy high for the frame only.
- Back-to-back frames 16'h0001 then 16'hFFFF with minimal SCK gap -> two o_RX_DV pulses, o_RX_Word 16'h0001 then 16'hFFFF, no o_Frame_Err.
- Send 5 SCK cycles then stop for IDLE_TIMEOUT+2 cycles -> o_Frame_Err pulses once at count 64, o_RX_DV never asserts, o_RX_Word keeps its previous value; a following full frame 16'hBEEF is received correctly.
- Assert i_Rst after byte 0 of a frame for 1 cycle -> all outputs 0 and state IDLE; the next full frame 16'h5AA5 yields o_RX_Word=16'h5AA5.
- Change i_TX_Word from 16'h1234 to 16'hFFFF after 3 bits of a frame -> master still receives 34,12; the next frame returns FF,FF.
- SCK half-period at the minimum (SYNC_STAGES+2 cycles) with random 16-bit words, 200 frames -> all words match both directions, zero errors.
